// File: rtl/rx_uart_pkg.sv
// rtl/rx_uart_pkg.sv - shared UART constants and state encodings for the rx and tx ends
package rx_uart_pkg;
  localparam int OVERSAMPLE  = 16;
  localparam int MID_TICK    = OVERSAMPLE / 2 - 1;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  typedef enum logic [2:0] {
    s_idle   = 3'd0,
    s_start  = 3'd1,
    s_data   = 3'd2,
    s_parity = 3'd3,
    s_stop   = 3'd4,
    s_break  = 3'd5
  } rx_state_t;

  typedef enum logic [1:0] {
    tx_idle  = 2'd0,
    tx_start = 2'd1,
    tx_data  = 2'd2,
    tx_stop  = 2'd3
  } tx_state_t;
endpackage

// File: rtl/rx_uart_sync.sv
// rtl/rx_uart_sync.sv - 2-flop synchronizer for an asynchronous input, both flops reset to 1
module rx_uart_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/rx_uart.sv
// rtl/rx_uart.sv - 16x-oversampled UART receiver; RX_UART_PARITY_EN adds a parity bit before stop
module rx_uart
  import rx_uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iRX,
  input  logic       iBaud_tick,
`ifdef RX_UART_PARITY_EN
  input  logic       iParity_odd,
`endif
  output logic [7:0] oData,
  output logic       oDone_tick,
  output logic       oErr
);
  localparam int ALIGN = 8 - DBIT;

  rx_state_t   state, state_n;
  logic [4:0]  tick_cnt, tick_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  data_n, frame_data;
  logic        done_n, err_n;
  logic        rx_s;
`ifdef RX_UART_PARITY_EN
  logic        par_bit, par_n;
`endif

  rx_uart_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (iRX),
    .q     (rx_s)
  );

  // Data arrives LSB first into the MSB, so short frames sit high and are realigned down
  assign frame_data = shreg >> ALIGN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= s_idle;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      oData      <= '0;
      oDone_tick <= 1'b0;
      oErr       <= 1'b0;
`ifdef RX_UART_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_n;
      bit_cnt    <= bit_n;
      shreg      <= shreg_n;
      oData      <= data_n;
      oDone_tick <= done_n;
      oErr       <= err_n;
`ifdef RX_UART_PARITY_EN
      par_bit    <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    data_n  = oData;
    done_n  = 1'b0;
    err_n   = 1'b0;
`ifdef RX_UART_PARITY_EN
    par_n   = par_bit;
`endif
    case (state)
      s_idle: begin
        if (!rx_s) begin
          state_n = s_start;
          tick_n  = '0;
        end
      end
      s_start: begin
        if (iBaud_tick) begin
          if (tick_cnt == 5'(MID_TICK)) begin
            if (!rx_s) begin
              state_n = s_data;
              tick_n  = '0;
              bit_n   = '0;
            end else begin
              state_n = s_idle;
            end
          end else begin
            tick_n = tick_cnt + 5'd1;
          end
        end
      end
      s_data: begin
        if (iBaud_tick) begin
          if (tick_cnt == 5'(OVERSAMPLE - 1)) begin
            shreg_n = {rx_s, shreg[7:1]};
            tick_n  = '0;
            if (bit_cnt == 3'(DBIT - 1)) begin
`ifdef RX_UART_PARITY_EN
              state_n = s_parity;
`else
              state_n = s_stop;
`endif
            end else begin
              bit_n = bit_cnt + 3'd1;
            end
          end else begin
            tick_n = tick_cnt + 5'd1;
          end
        end
      end
`ifdef RX_UART_PARITY_EN
      s_parity: begin
        if (iBaud_tick) begin
          if (tick_cnt == 5'(OVERSAMPLE - 1)) begin
            par_n   = rx_s;
            tick_n  = '0;
            state_n = s_stop;
          end else begin
            tick_n = tick_cnt + 5'd1;
          end
        end
      end
`endif
      s_stop: begin
        if (iBaud_tick) begin
          if (tick_cnt == 5'(SB_TICK - 1)) begin
            if (!rx_s) begin
              err_n   = 1'b1;
              state_n = s_break;
`ifdef RX_UART_PARITY_EN
            end else if ((^frame_data ^ par_bit) != iParity_odd) begin
              err_n   = 1'b1;
              state_n = s_idle;
`endif
            end else begin
              data_n  = frame_data;
              done_n  = 1'b1;
              state_n = s_idle;
            end
          end else begin
            tick_n = tick_cnt + 5'd1;
          end
        end
      end
      s_break: begin
        // A held-low line must go high before the next start bit can be seen
        if (rx_s) state_n = s_idle;
      end
      default: state_n = s_idle;
    endcase
  end
endmodule
